vx_issue_sched: RTL and testbench
=================================

VX_ISSUE_SCHED -- requirements
Module: VX_issue_sched

Interface
REQ-001 SHALL have parameter NUM_WARPS, default 4, number of warp instruction-buffer heads (power of 2, >=2).
REQ-002 SHALL have parameter NUM_REGS, default 32, architectural registers per warp (power of 2); RB = log2(NUM_REGS), WB = log2(NUM_WARPS).
REQ-003 SHALL have parameter TIMEOUT, default 1000, stall-cycle limit for the timeout flag.
REQ-004 SHALL have parameter PERF_BITS, default 32, performance counter width.
REQ-005 Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- ibuf_valid  in  NUM_WARPS  per-warp head instruction valid.
- ibuf_ready  out  NUM_WARPS  per-warp head consumed.
- ibuf_wb  in  NUM_WARPS  head instruction writes rd.
- ibuf_rd, ibuf_rs1, ibuf_rs2, ibuf_rs3  in  NUM_WARPS*RB each  head register indices; warp w occupies bits [w*RB +: RB].
- wb_valid  in  1  writeback valid.
- wb_wid  in  WB  writeback warp.
- wb_rd  in  RB  writeback register.
- wb_eop  in  1  last packet of the writeback.
- disp_valid  out  1  instruction offered to dispatch.
- disp_wid  out  WB  selected warp.
- disp_ready  in  1  dispatch accepts.
- timeout  out  1  stall limit reached.
- perf_scb_stalls, perf_disp_stalls  out  PERF_BITS each  (present only per REQ-021).

Function
REQ-006 SHALL keep an in-use bit per (warp, register), NUM_WARPS*NUM_REGS bits; register 0 SHALL never be marked in use.
REQ-007 Warp w SHALL be eligible when ibuf_valid[w] and none of its rs1, rs2, rs3, or (if ibuf_wb[w]) rd is in use; the check reads registered in-use state only, no writeback bypass.
REQ-008 Selection SHALL be round-robin over eligible warps, starting at the warp after the last issued warp (pointer reset value NUM_WARPS-1, so warp 0 has first priority).
REQ-009 disp_valid SHALL be high combinationally when any warp is eligible; disp_wid SHALL equal the selected warp (0 when none).
REQ-010 Issue fires when disp_valid && disp_ready; ibuf_ready SHALL be one-hot at the selected warp on fire, else all zero; zero-cycle latency.
REQ-011 The round-robin pointer SHALL update to the issued warp only on fire; held otherwise.
REQ-012 On fire with ibuf_wb set and rd != 0, the in-use bit (disp_wid, rd) SHALL set on the next edge.
REQ-013 On wb_valid && wb_eop, in-use bit (wb_wid, wb_rd) SHALL clear on the next edge; wb_valid without wb_eop SHALL not change state.
REQ-014 Simultaneous set and clear of the same bit: set SHALL win.
REQ-015 Stall counter SHALL increment, saturating at TIMEOUT, in cycles with any ibuf_valid and no fire, and SHALL clear on fire or when no ibuf_valid is high.
REQ-016 timeout SHALL be high while the stall counter equals TIMEOUT.

Reset
REQ-017 On reset all in-use bits SHALL clear, pointer = NUM_WARPS-1, stall counter = 0, perf counters = 0.
REQ-018 During reset disp_valid, ibuf_ready, timeout SHALL be 0 regardless of inputs.
REQ-019 Reset asserted mid-operation SHALL discard pending in-use state; the first post-reset cycle behaves as after power-up.
REQ-020 Outputs after reset: disp_valid=0 until an eligible warp exists, disp_wid=0, ibuf_ready=0, timeout=0.

Configuration
REQ-021 Macro ISSUE_PERF_EN: when defined, perf_scb_stalls SHALL increment (wrapping) in cycles with any ibuf_valid but no eligible warp, and perf_disp_stalls in cycles with disp_valid && !disp_ready; when undefined these ports and counters SHALL not exist and all other behaviour is identical.

Verification
REQ-022 Warps 0..3 valid, no hazards, disp_ready=1 for 4 cycles -> disp_wid sequence 0,1,2,3, one-hot ibuf_ready each cycle.
REQ-023 Warp 1 issues wb=1 rd=5; next cycle warp 1 head has rs1=5 -> warp 1 ineligible until wb_valid, wb_eop, wb_wid=1, wb_rd=5, eligible the following cycle.
REQ-024 Issue wb=1 rd=0 then head reading rs2=0 -> no stall, issues next cycle.
REQ-025 Same-cycle issue of (warp 2, rd=7) and writeback eop of (2,7) -> bit (2,7) set afterwards; warp 2 reading r7 stalls.
REQ-026 TIMEOUT=8, warp 0 valid, disp_ready=0 -> timeout rises after 8 stall cycles, clears the cycle after disp_ready=1 fires; with ISSUE_PERF_EN perf_disp_stalls = 8 or more.
REQ-027 Assert reset for 1 cycle with bits in use -> all warps eligible immediately after, pointer restarts at warp 0.

Source files
------------

// File: rtl/vx_issue_sched.sv
`default_nettype none
// ============================================================================
// Module   : vx_issue_sched
// Purpose  : Warp issue scheduler with a per-warp register scoreboard.
//            A warp is eligible when its instruction-buffer head is valid and
//            none of its source registers, nor its destination register when
//            it writes one, is marked in use. Eligible warps are picked
//            round-robin, starting after the last issued warp. An issue marks
//            the destination register in use. A final writeback packet clears
//            that mark. A stall counter raises timeout when no issue has
//            happened for TIMEOUT consecutive cycles while work is pending.
// Ports    : clk, reset (sync, active-high)
//            ibuf_valid/ready/wb, ibuf_rd/rs1/rs2/rs3 : per-warp head info
//            wb_valid/wid/rd/eop                      : writeback release
//            disp_valid/wid/ready                     : dispatch handshake
//            timeout                                  : stall limit reached
//            perf_scb_stalls, perf_disp_stalls        : only with ISSUE_PERF_EN
// Config   : `define ISSUE_PERF_EN adds the two wrapping perf counters.
// Revision : 1.0 - initial release
// ============================================================================
module vx_issue_sched #(
  parameter int NUM_WARPS = 4,
  parameter int NUM_REGS  = 32,
  parameter int TIMEOUT   = 1000,
  parameter int PERF_BITS = 32,
  localparam int RB = $clog2(NUM_REGS),
  localparam int WB = $clog2(NUM_WARPS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_WARPS-1:0]    ibuf_valid,
  output logic [NUM_WARPS-1:0]    ibuf_ready,
  input  logic [NUM_WARPS-1:0]    ibuf_wb,
  input  logic [NUM_WARPS*RB-1:0] ibuf_rd,
  input  logic [NUM_WARPS*RB-1:0] ibuf_rs1,
  input  logic [NUM_WARPS*RB-1:0] ibuf_rs2,
  input  logic [NUM_WARPS*RB-1:0] ibuf_rs3,
  input  logic                    wb_valid,
  input  logic [WB-1:0]           wb_wid,
  input  logic [RB-1:0]           wb_rd,
  input  logic                    wb_eop,
  output logic                    disp_valid,
  output logic [WB-1:0]           disp_wid,
  input  logic                    disp_ready,
  output logic                    timeout
`ifdef ISSUE_PERF_EN
  ,
  output logic [PERF_BITS-1:0]    perf_scb_stalls,
  output logic [PERF_BITS-1:0]    perf_disp_stalls
`endif
);

  localparam int            SW        = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STALL_MAX = SW'(TIMEOUT);

  logic [NUM_WARPS-1:0][NUM_REGS-1:0] inuse_q, inuse_d;
  logic [WB-1:0]                      rr_q, rr_d;
  logic [SW-1:0]                      stall_q, stall_d;

  logic [NUM_WARPS-1:0] eligible;
  logic [RB-1:0]        rd_arr [NUM_WARPS];
  logic                 sel_found;
  logic [WB-1:0]        sel_wid;
  logic [WB-1:0]        cand;
  logic                 fire;
  logic                 any_valid;

  // Hazard check against registered scoreboard state only (no bypass).
  for (genvar w = 0; w < NUM_WARPS; w++) begin : g_elig
    logic [RB-1:0] rs1_w, rs2_w, rs3_w;
    assign rd_arr[w]   = ibuf_rd [w*RB +: RB];
    assign rs1_w       = ibuf_rs1[w*RB +: RB];
    assign rs2_w       = ibuf_rs2[w*RB +: RB];
    assign rs3_w       = ibuf_rs3[w*RB +: RB];
    assign eligible[w] = ibuf_valid[w]
                       && !inuse_q[w][rs1_w]
                       && !inuse_q[w][rs2_w]
                       && !inuse_q[w][rs3_w]
                       && !(ibuf_wb[w] && inuse_q[w][rd_arr[w]]);
  end

  // Round-robin scan from the warp after rr_q; the last candidate wraps back
  // to rr_q itself because NUM_WARPS is a power of two.
  always_comb begin
    sel_found = 1'b0;
    sel_wid   = '0;
    cand      = '0;
    for (int i = 1; i <= NUM_WARPS; i++) begin
      cand = rr_q + WB'(i);
      if (!sel_found && eligible[cand]) begin
        sel_found = 1'b1;
        sel_wid   = cand;
      end
    end
  end

  assign any_valid  = |ibuf_valid;
  assign disp_valid = sel_found && !reset;
  assign disp_wid   = sel_wid;
  assign fire       = disp_valid && disp_ready;
  assign ibuf_ready = fire ? ({{(NUM_WARPS-1){1'b0}}, 1'b1} << sel_wid) : '0;
  assign timeout    = !reset && (stall_q == STALL_MAX);

  always_comb begin
    rr_d    = fire ? sel_wid : rr_q;
    inuse_d = inuse_q;
    if (wb_valid && wb_eop) begin
      inuse_d[wb_wid][wb_rd] = 1'b0;
    end
    // Applied after the clear so that a same-cycle set wins.
    if (fire && ibuf_wb[sel_wid] && (rd_arr[sel_wid] != '0)) begin
      inuse_d[sel_wid][rd_arr[sel_wid]] = 1'b1;
    end
    if (fire || !any_valid) begin
      stall_d = '0;
    end else if (stall_q != STALL_MAX) begin
      stall_d = stall_q + SW'(1);
    end else begin
      stall_d = stall_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      inuse_q <= '0;
      rr_q    <= WB'(NUM_WARPS - 1);
      stall_q <= '0;
    end else begin
      inuse_q <= inuse_d;
      rr_q    <= rr_d;
      stall_q <= stall_d;
    end
  end

`ifdef ISSUE_PERF_EN
  logic [PERF_BITS-1:0] perf_scb_q, perf_disp_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_scb_q  <= '0;
      perf_disp_q <= '0;
    end else begin
      if (any_valid && !sel_found) begin
        perf_scb_q <= perf_scb_q + PERF_BITS'(1);
      end
      if (disp_valid && !disp_ready) begin
        perf_disp_q <= perf_disp_q + PERF_BITS'(1);
      end
    end
  end

  assign perf_scb_stalls  = perf_scb_q;
  assign perf_disp_stalls = perf_disp_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vx_issue_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_vx_issue_sched
// Purpose  : Directed scoreboard bench for vx_issue_sched (4 warps, 32 regs,
//            TIMEOUT=8). Stimulus pushes the expected issued warp into a queue;
//            a monitor pops and compares on every dispatch handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vx_issue_sched;

  localparam int NW = 4;
  localparam int RB = 5;
  localparam int WB = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [NW-1:0]   ibuf_valid, ibuf_ready, ibuf_wb;
  logic [NW*RB-1:0] ibuf_rd, ibuf_rs1, ibuf_rs2, ibuf_rs3;
  logic            wb_valid, wb_eop;
  logic [WB-1:0]   wb_wid;
  logic [RB-1:0]   wb_rd;
  logic            disp_valid, disp_ready, timeout;
  logic [WB-1:0]   disp_wid;
`ifdef ISSUE_PERF_EN
  logic [31:0]     perf_scb_stalls, perf_disp_stalls;
`endif

  int errors = 0;
  int checks = 0;
  int exp_q[$];

  vx_issue_sched #(
    .NUM_WARPS(NW), .NUM_REGS(32), .TIMEOUT(8), .PERF_BITS(32)
  ) dut (
    .clk(clk), .reset(reset),
    .ibuf_valid(ibuf_valid), .ibuf_ready(ibuf_ready), .ibuf_wb(ibuf_wb),
    .ibuf_rd(ibuf_rd), .ibuf_rs1(ibuf_rs1), .ibuf_rs2(ibuf_rs2), .ibuf_rs3(ibuf_rs3),
    .wb_valid(wb_valid), .wb_wid(wb_wid), .wb_rd(wb_rd), .wb_eop(wb_eop),
    .disp_valid(disp_valid), .disp_wid(disp_wid), .disp_ready(disp_ready),
    .timeout(timeout)
`ifdef ISSUE_PERF_EN
    , .perf_scb_stalls(perf_scb_stalls), .perf_disp_stalls(perf_disp_stalls)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic set_head(input int w, input logic v, input logic wbb,
                          input logic [RB-1:0] rd, input logic [RB-1:0] r1,
                          input logic [RB-1:0] r2, input logic [RB-1:0] r3);
    ibuf_valid[w]          = v;
    ibuf_wb[w]             = wbb;
    ibuf_rd [w*RB +: RB]   = rd;
    ibuf_rs1[w*RB +: RB]   = r1;
    ibuf_rs2[w*RB +: RB]   = r2;
    ibuf_rs3[w*RB +: RB]   = r3;
  endtask

  task automatic clear_heads();
    ibuf_valid = '0; ibuf_wb = '0;
    ibuf_rd = '0; ibuf_rs1 = '0; ibuf_rs2 = '0; ibuf_rs3 = '0;
  endtask

  // Inputs change 1 time unit after the rising edge; checks run 2 units later.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  // Monitor: compares every handshake against the scoreboard queue.
  initial begin
    int e;
    forever begin
      @(negedge clk);
      if (disp_valid && disp_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_issue: actual wid=%0d required no issue", disp_wid);
        end else begin
          e = exp_q.pop_front();
          chk("disp_wid", 32'(disp_wid), 32'(e));
          chk("ibuf_ready_onehot", 32'(ibuf_ready), 32'(1) << e);
        end
      end else begin
        chk("ibuf_ready_idle", 32'(ibuf_ready), 32'h0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    clear_heads();
    wb_valid = 1'b0; wb_eop = 1'b0; wb_wid = '0; wb_rd = '0;
    // Reset with every warp valid and dispatch ready: outputs must stay low.
    ibuf_valid = '1;
    disp_ready = 1'b1;
    next_cycle(); settle();
    chk("reset_disp_valid", 32'(disp_valid), 0);
    chk("reset_timeout", 32'(timeout), 0);
    next_cycle();
    reset = 1'b0;
    clear_heads();
    disp_ready = 1'b0;
    settle();
    chk("post_reset_disp_valid", 32'(disp_valid), 0);
    chk("post_reset_disp_wid", 32'(disp_wid), 0);
    chk("post_reset_timeout", 32'(timeout), 0);
    next_cycle();

    // Round-robin across four hazard-free warps.
    ibuf_valid = '1;
    disp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(i);
      settle();
      next_cycle();
    end
    clear_heads();

    // RAW hazard on warp 1 r5, released only by an eop writeback.
    set_head(1, 1, 1, 5, 0, 0, 0);
    exp_q.push_back(1);
    settle(); next_cycle();
    set_head(1, 1, 0, 0, 5, 0, 0);
    settle(); chk("raw_stall_a", 32'(disp_valid), 0); next_cycle();
    settle(); chk("raw_stall_b", 32'(disp_valid), 0); next_cycle();
    wb_valid = 1'b1; wb_eop = 1'b0; wb_wid = 2'd1; wb_rd = 5'd5;
    settle(); chk("raw_stall_wb_noeop", 32'(disp_valid), 0); next_cycle();
    wb_valid = 1'b0;
    settle(); chk("noeop_keeps_bit", 32'(disp_valid), 0); next_cycle();
    wb_valid = 1'b1; wb_eop = 1'b1;
    settle(); chk("no_wb_bypass", 32'(disp_valid), 0); next_cycle();
    wb_valid = 1'b0; wb_eop = 1'b0;
    exp_q.push_back(1);
    settle(); chk("raw_released", 32'(disp_valid), 1); next_cycle();
    clear_heads();

    // rd=0 is never tracked.
    set_head(3, 1, 1, 0, 0, 0, 0);
    exp_q.push_back(3);
    settle(); next_cycle();
    set_head(3, 1, 0, 0, 3, 0, 4);
    exp_q.push_back(3);
    settle(); chk("r0_no_stall", 32'(disp_valid), 1); next_cycle();
    clear_heads();

    // Same-cycle set and clear of (2,7): set wins.
    set_head(2, 1, 1, 7, 0, 0, 0);
    wb_valid = 1'b1; wb_eop = 1'b1; wb_wid = 2'd2; wb_rd = 5'd7;
    exp_q.push_back(2);
    settle(); next_cycle();
    wb_valid = 1'b0; wb_eop = 1'b0;
    set_head(2, 1, 0, 0, 0, 0, 7);
    settle(); chk("set_wins_a", 32'(disp_valid), 0); next_cycle();
    settle(); chk("set_wins_b", 32'(disp_valid), 0); next_cycle();
    wb_valid = 1'b1; wb_eop = 1'b1;
    settle(); chk("set_wins_c", 32'(disp_valid), 0); next_cycle();
    wb_valid = 1'b0; wb_eop = 1'b0;
    exp_q.push_back(2);
    settle(); next_cycle();
    clear_heads();

    // Pointer at 2: warps 0 and 3 valid, warp 3 is next in order.
    set_head(0, 1, 0, 0, 0, 0, 0);
    set_head(3, 1, 0, 0, 0, 0, 0);
    disp_ready = 1'b0;
    settle();
    chk("rr_offer_valid", 32'(disp_valid), 1);
    chk("rr_offer_wid", 32'(disp_wid), 3);
    chk("no_ready_no_consume", 32'(ibuf_ready), 0);
    next_cycle();
    disp_ready = 1'b1;
    exp_q.push_back(3); settle(); next_cycle();
    exp_q.push_back(0); settle(); next_cycle();
    clear_heads();

    // Mark (1,9) and (2,9) in use, then reset mid-operation.
    set_head(1, 1, 1, 9, 0, 0, 0);
    exp_q.push_back(1); settle(); next_cycle();
    clear_heads();
    set_head(2, 1, 1, 9, 0, 0, 0);
    exp_q.push_back(2); settle(); next_cycle();
    clear_heads();
    for (int w = 0; w < 4; w++) set_head(w, 1, 0, 0, 9, 0, 0);
    disp_ready = 1'b0;
    settle();
    chk("pre_reset_wid", 32'(disp_wid), 3);
    next_cycle();
    reset = 1'b1;
    settle();
    chk("midreset_disp_valid", 32'(disp_valid), 0);
    chk("midreset_timeout", 32'(timeout), 0);
    next_cycle();
    reset = 1'b0;
    settle();
    chk("after_reset_valid", 32'(disp_valid), 1);
    chk("after_reset_wid", 32'(disp_wid), 0);
    next_cycle();
    disp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(i);
      settle();
      next_cycle();
    end
    clear_heads();
    disp_ready = 1'b0;
    settle(); next_cycle();

    // Stall timeout: warp 0 waits with dispatch not ready.
    set_head(0, 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 10; k++) begin
      settle();
      chk($sformatf("timeout_cycle%0d", k), 32'(timeout), (k >= 8) ? 32'd1 : 32'd0);
      next_cycle();
    end
    disp_ready = 1'b1;
    exp_q.push_back(0);
    settle();
    chk("timeout_in_fire_cycle", 32'(timeout), 1);
    next_cycle();
    disp_ready = 1'b0;
    settle();
    chk("timeout_cleared", 32'(timeout), 0);
`ifdef ISSUE_PERF_EN
    chk("perf_disp_stalls_ge8", 32'(perf_disp_stalls >= 32'd8), 1);
`endif
    next_cycle();
    clear_heads();
    next_cycle();
    next_cycle();
    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
